// File: rtl/lfsr15_key_driver_if.sv
// lfsr15_key_driver_if: control/key bundle between the key driver and its harness.
// Signals: start, hold (only with KEY_DRV_HOLD_EN), code[14:0], busy, done.
interface lfsr15_key_driver_if;
  logic        start;
`ifdef KEY_DRV_HOLD_EN
  logic        hold;
`endif
  logic [14:0] code;
  logic        busy;
  logic        done;

  // driver side
  modport master (
    input  start,
`ifdef KEY_DRV_HOLD_EN
    input  hold,
`endif
    output code,
    output busy,
    output done
  );

  // harness side
  modport slave (
    output start,
`ifdef KEY_DRV_HOLD_EN
    output hold,
`endif
    input  code,
    input  busy,
    input  done
  );
endinterface

// File: rtl/lfsr15_key_driver.sv
// lfsr15_key_driver: mirrors the lock's 15-bit LFSR and presents STEPS keys per start.
// Ports: clk, rst (sync, active high), bus (master: start, hold, code, busy, done).
// Optional macro KEY_DRV_HOLD_EN adds the hold input that pauses a run.
module lfsr15_key_driver #(
  parameter int          STEPS = 11,
  parameter logic [14:0] SEED  = 15'h0001
) (
  input  logic clk,
  input  logic rst,
  lfsr15_key_driver_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam bit          NO_STEPS = (STEPS == 0);
  localparam logic [14:0] LAST     =
    NO_STEPS ? 15'd0 : 15'(STEPS - 1);

  state_t      st;
  logic [14:0] m;
  logic [14:0] cnt;
  logic        busy_q;
  logic        done_q;
  logic        hold_i;
  logic        key;

`ifdef KEY_DRV_HOLD_EN
  assign hold_i = bus.hold;
`else
  assign hold_i = 1'b0;
`endif

  // A key is on the bus exactly when the lock will compare and step.
  assign key = (st == RUN) && !hold_i;

  function automatic logic [14:0] lfsr_next(
    input logic [14:0] v
  );
    return {v[13:0], v[13] ^ v[14]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      m      <= SEED;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (bus.start) begin
            if (NO_STEPS) begin
              st     <= DONE;
              done_q <= 1'b1;
            end else begin
              st     <= RUN;
              cnt    <= '0;
              busy_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (key) begin
            m   <= lfsr_next(m);
            cnt <= cnt + 15'd1;
            if (cnt == LAST) begin
              st     <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          st     <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          st     <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // 0 never matches a nonzero LFSR, so an idle bus cannot advance the lock.
  assign bus.code = key ? m : 15'h0000;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_lfsr15_key_driver.sv
// tb_lfsr15_key_driver: four drivers (STEPS 11,3,0,2) under directed and random stimulus.
// A transaction-level model predicts code/busy/done each cycle.
module tb_lfsr15_key_driver;

  localparam int N = 4;
  localparam int ST [N] = '{11, 3, 0, 2};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  start_v = '0;
  logic [N-1:0]  hold_v = '0;
  logic [14:0]   code_w [N];
  logic [N-1:0]  busy_w;
  logic [N-1:0]  done_w;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : gi
    lfsr15_key_driver_if b ();
    lfsr15_key_driver #(
      .STEPS (ST[g]),
      .SEED  (15'h0001)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (b)
    );
    assign b.start   = start_v[g];
`ifdef KEY_DRV_HOLD_EN
    assign b.hold    = hold_v[g];
`endif
    assign code_w[g] = b.code;
    assign busy_w[g] = b.busy;
    assign done_w[g] = b.done;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] lfsr_step(
    input logic [14:0] v
  );
    int t;
    t = (int'(v) * 2) % 32768;
    t = t + (((int'(v) >> 13) ^ (int'(v) >> 14)) & 1);
    return 15'(t);
  endfunction

  // model: keys still owed, pending done, mirror value
  int          left [N] = '{0, 0, 0, 0};
  bit          dpend [N] = '{0, 0, 0, 0};
  logic [14:0] mref [N] = '{15'h1, 15'h1, 15'h1, 15'h1};

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        left[i]  <= 0;
        dpend[i] <= 1'b0;
        mref[i]  <= 15'h0001;
      end else if (dpend[i]) begin
        dpend[i] <= 1'b0;
      end else if (left[i] > 0) begin
        if (!hold_v[i]) begin
          mref[i] <= lfsr_step(mref[i]);
          left[i] <= left[i] - 1;
          if (left[i] == 1) dpend[i] <= 1'b1;
        end
      end else if (start_v[i]) begin
        if (ST[i] == 0) dpend[i] <= 1'b1;
        else left[i] <= ST[i];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("m_code%0d", i), 32'(code_w[i]),
            (left[i] > 0 && !hold_v[i]) ? 32'(mref[i]) : 32'd0);
        chk($sformatf("m_busy%0d", i), 32'(busy_w[i]),
            32'(left[i] > 0));
        chk($sformatf("m_done%0d", i), 32'(done_w[i]),
            32'(dpend[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [14:0] run2 [5] = '{15'h0800, 15'h1000, 15'h2000,
                            15'h4001, 15'h0003};
  logic [14:0] cont [6] = '{15'h1, 15'h2, 15'h0, 15'h0,
                            15'h4, 15'h8};

  initial begin
    rst = 1'b1;
    step();
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_code", 32'(code_w[0]), 32'd0);
    chk("rst_busy", 32'(busy_w), 32'd0);
    chk("rst_done", 32'(done_w), 32'd0);
    rst = 1'b0;
    step();

    // first run on all drivers
    start_v = '1;
    step();
    start_v = '0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      chk($sformatf("run1_k%0d", k), 32'(code_w[0]), 32'(1) << k);
      chk("run1_busy", 32'(busy_w[0]), 32'd1);
      if (k == 0) begin
        chk("z_done", 32'(done_w[2]), 32'd1);
        chk("z_code", 32'(code_w[2]), 32'd0);
      end
      step();
    end
    @(negedge clk);
    chk("run1_done", 32'(done_w[0]), 32'd1);
    chk("run1_nbusy", 32'(busy_w[0]), 32'd0);
    step();
    step();

    // second run continues the sequence
    start_v = 4'b0001;
    step();
    start_v = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("run2_k%0d", k), 32'(code_w[0]), 32'(run2[k]));
      step();
    end
    repeat (10) step();

    // reset in the third RUN cycle
    start_v = 4'b0001;
    step();
    start_v = '0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_code", 32'(code_w[0]), 32'd0);
    chk("mrst_busy", 32'(busy_w[0]), 32'd0);
    start_v = 4'b0001;
    step();
    start_v = '0;
    @(negedge clk);
    chk("mrst_first", 32'(code_w[0]), 32'h0001);
    repeat (14) step();

`ifdef KEY_DRV_HOLD_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    start_v = 4'b0010;
    step();
    start_v = '0;
    @(negedge clk);
    chk("hold_k0", 32'(code_w[1]), 32'h0001);
    step();
    hold_v = 4'b0010;
    @(negedge clk);
    chk("hold_k1", 32'(code_w[1]), 32'h0000);
    chk("hold_busy", 32'(busy_w[1]), 32'd1);
    step();
    hold_v = '0;
    @(negedge clk);
    chk("hold_k2", 32'(code_w[1]), 32'h0002);
    step();
    @(negedge clk);
    chk("hold_k3", 32'(code_w[1]), 32'h0004);
    step();
    @(negedge clk);
    chk("hold_done", 32'(done_w[1]), 32'd1);
    step();
`endif

    // start held high on the STEPS=2 driver
    rst = 1'b1;
    step();
    rst = 1'b0;
    start_v = 4'b1000;
    step();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("cont_k%0d", k), 32'(code_w[3]), 32'(cont[k]));
      step();
    end
    start_v = '0;
    repeat (4) step();

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      start_v = N'($urandom);
      rst = ($urandom_range(0, 63) == 0);
`ifdef KEY_DRV_HOLD_EN
      hold_v = N'($urandom) & N'($urandom);
`endif
      step();
    end
    rst = 1'b0;
    start_v = '0;
    hold_v = '0;
    step();
    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
